// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for one shared memory port among four requesters.
// Grants one requester at a time, waits for ack or watchdog, then rotates.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       mem_ack,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       mem_valid,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] wdog;
    logic [1:0]    win;
    logic          found;
    logic          wdog_exp;

    assign wdog_exp = (wdog == CW'(TIMEOUT - 1));

    // First requester at or after ptr in circular order wins.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr + 2'(i)]) begin
                found = 1'b1;
                win   = ptr + 2'(i);
            end
        end
    end

    // Grant/transfer sequencer with watchdog and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= 4'b0000;
            sel         <= 2'b00;
            mem_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            ptr         <= 2'b00;
            wdog        <= '0;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state     <= BUSY;
                        gnt       <= 4'b0001 << win;
                        sel       <= win;
                        mem_valid <= 1'b1;
                        busy      <= 1'b1;
                        wdog      <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack || wdog_exp) begin
                        state       <= IDLE;
                        gnt         <= 4'b0000;
                        mem_valid   <= 1'b0;
                        busy        <= 1'b0;
                        ptr         <= sel + 2'd1;
                        timeout_err <= !mem_ack;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Inputs change 1 time unit after posedge; outputs sampled there too.
module tb_mem_port_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       mem_ack;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       mem_valid;
    logic       busy;
    logic       timeout_err;

    int checks;
    int errors;

    mem_port_arbiter #(.TIMEOUT(16), .CW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .mem_ack     (mem_ack),
        .gnt         (gnt),
        .sel         (sel),
        .mem_valid   (mem_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [1:0] s);
        check({tag, " gnt"}, 32'(gnt), 32'h0);
        check({tag, " mv"}, 32'(mem_valid), 32'h0);
        check({tag, " busy"}, 32'(busy), 32'h0);
        check({tag, " sel"}, 32'(sel), 32'(s));
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] g,
                           input logic [1:0] s);
        check({tag, " gnt"}, 32'(gnt), 32'(g));
        check({tag, " sel"}, 32'(sel), 32'(s));
        check({tag, " mv"}, 32'(mem_valid), 32'h1);
        check({tag, " busy"}, 32'(busy), 32'h1);
    endtask

    logic [3:0] order [5];
    logic [1:0] oidx  [5];
    int         cnt;
    bit         done;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        req     = 4'b0000;
        mem_ack = 1'b0;
        order   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        oidx    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        tick();
        tick();
        chk_idle("rst", 2'd0);
        check("rst terr", 32'(timeout_err), 32'h0);
        rst_n = 1'b1;

        // single requester 2, ack after 3 busy cycles
        req = 4'b0100;
        tick();
        chk_gnt("t2 grant", 4'b0100, 2'd2);
        tick();
        tick();
        chk_gnt("t2 hold", 4'b0100, 2'd2);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk_idle("t2 rel", 2'd2);
        req = 4'b1111;
        tick();
        chk_gnt("t2 next", 4'b1000, 2'd3);

        // all requesting: rotation 0,1,2,3,0 with idle between
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk_idle("t3 rel3", 2'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_gnt($sformatf("t3 g%0d", i), order[i], oidx[i]);
            mem_ack = 1'b1;
            if (i == 4) req = 4'b0010;
            tick();
            mem_ack = 1'b0;
            chk_idle($sformatf("t3 i%0d", i), oidx[i]);
        end

        // watchdog abort on requester 1
        tick();
        chk_gnt("t4 grant", 4'b0010, 2'd1);
        check("t4 terr busy", 32'(timeout_err), 32'h0);
        cnt  = 1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (mem_valid) cnt++;
            else done = 1'b1;
        end
        req = 4'b1111;
        check("t4 released", 32'(done), 32'h1);
        check("t4 busy len", 32'(cnt), 32'd16);
        check("t4 terr", 32'(timeout_err), 32'h1);
        chk_idle("t4 rel", 2'd1);
        tick();
        check("t4 terr pulse", 32'(timeout_err), 32'h0);
        chk_gnt("t4 ptr2", 4'b0100, 2'd2);

        // ack coincides with watchdog expiry
        req = 4'b0000;
        for (int i = 0; i < 15; i++) tick();
        chk_gnt("t5 hold", 4'b0100, 2'd2);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk_idle("t5 rel", 2'd2);
        check("t5 terr", 32'(timeout_err), 32'h0);
        tick();
        check("t5 terr2", 32'(timeout_err), 32'h0);

        // req drop while busy, stray ack while idle
        req = 4'b1000;
        tick();
        chk_gnt("t6 grant", 4'b1000, 2'd3);
        req = 4'b0000;
        tick();
        tick();
        chk_gnt("t6 hold", 4'b1000, 2'd3);
        mem_ack = 1'b1;
        tick();
        chk_idle("t6 rel", 2'd3);
        tick();
        mem_ack = 1'b0;
        chk_idle("t6 stray", 2'd3);
        check("t6 terr", 32'(timeout_err), 32'h0);

        // async reset mid-transfer
        req = 4'b0100;
        tick();
        chk_gnt("t1 grant", 4'b0100, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("t1 async", 2'd0);
        tick();
        rst_n = 1'b1;
        req   = 4'b1111;
        tick();
        chk_gnt("t1 after", 4'b0001, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
